// File: rtl/layer_sched_pkg.sv
// Shared constants for the layer enable scheduler.
// Provides the FSM state codes, the 2-bit phase codes driven on the phase
// output, the default field widths and a small state classification helper.
package layer_sched_pkg;

  localparam int DEF_DIV_W  = 8;
  localparam int DEF_STEP_W = 12;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_CONV = 3'd1;
  localparam state_t ST_POOL = 3'd2;
  localparam state_t ST_DENS = 3'd3;
  localparam state_t ST_DONE = 3'd4;

  localparam logic [1:0] PHASE_CONV = 2'd0;
  localparam logic [1:0] PHASE_POOL = 2'd1;
  localparam logic [1:0] PHASE_DENS = 2'd2;
  localparam logic [1:0] PHASE_IDLE = 2'd3;

  function automatic logic is_run(input state_t s);
    return (s == ST_CONV) || (s == ST_POOL) || (s == ST_DENS);
  endfunction

endpackage

// File: rtl/layer_strobe_gen.sv
// Divided-strobe generator shared by all three phases.
// The counter runs 0..div_m1 and wraps; tick is registered, so every control
// input describes the cycle that follows the coming clock edge.
// Ports:
//   clock_in  system clock
//   reset     synchronous active-high reset
//   clear     next cycle is a phase entry: counter restarts at 0
//   hold      freeze the counter for this cycle
//   run       next cycle may strobe (active phase with a non-zero step count)
//   div_m1    strobe period minus one for the next cycle
//   tick      registered one-cycle strobe
module layer_strobe_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             clear,
  input  logic             hold,
  input  logic             run,
  input  logic [DIV_W-1:0] div_m1,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  always_comb begin
    if (clear)                 cnt_d = '0;
    else if (hold)             cnt_d = cnt_q;
    else if (cnt_q == div_m1)  cnt_d = '0;
    else                       cnt_d = cnt_q + 1'b1;
  end

  // A held counter sitting at div_m1 keeps tick high, so a strobe masked by
  // a hold is issued on the first cycle after the hold is released.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tick  <= run && (cnt_d == div_m1);
    end
  end

endmodule

// File: rtl/layer_enable_scheduler.sv
// Sequences the CNN pipeline through conv, maxpool and dense phases, issuing
// single-cycle clock-enable strobes at a programmed divisor for a programmed
// number of steps per phase. Configuration is captured on start.
// Optional feature macro: LAYER_SCHED_PAUSE_EN adds the pause input, which
// freezes the active phase while high.
// Ports:
//   clock_in, reset             clock, synchronous active-high reset
//   start                       run request, honoured only in IDLE
//   cfg_div_*  [DIV_W-1:0]      per-phase strobe period (0 and 1 mean 1)
//   cfg_steps_*[STEP_W-1:0]     per-phase strobe count
//   pause                       hold request (LAYER_SCHED_PAUSE_EN only)
//   en_conv/en_pool/en_dens     one-cycle enable strobes
//   phase [1:0]                 0 conv, 1 pool, 2 dense, 3 idle/done
//   step_idx [STEP_W-1:0]       strobes already issued in the current phase
//   busy, done                  run in progress, one-cycle end-of-run pulse
//
// state | meaning
// IDLE  | waiting for start, phase=3
// CONV  | conv strobes at div_conv until steps_conv issued
// POOL  | maxpool strobes at div_pool until steps_pool issued
// DENS  | dense strobes at div_dens until steps_dens issued
// DONE  | one-cycle done pulse, then IDLE
module layer_enable_scheduler
  import layer_sched_pkg::*;
#(
  parameter int DIV_W  = DEF_DIV_W,
  parameter int STEP_W = DEF_STEP_W
) (
  input  logic              clock_in,
  input  logic              reset,
  input  logic              start,
  input  logic [DIV_W-1:0]  cfg_div_conv,
  input  logic [DIV_W-1:0]  cfg_div_pool,
  input  logic [DIV_W-1:0]  cfg_div_dens,
  input  logic [STEP_W-1:0] cfg_steps_conv,
  input  logic [STEP_W-1:0] cfg_steps_pool,
  input  logic [STEP_W-1:0] cfg_steps_dens,
`ifdef LAYER_SCHED_PAUSE_EN
  input  logic              pause,
`endif
  output logic              en_conv,
  output logic              en_pool,
  output logic              en_dens,
  output logic [1:0]        phase,
  output logic [STEP_W-1:0] step_idx,
  output logic              busy,
  output logic              done
);

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_conv_q, div_pool_q, div_dens_q;
  logic [STEP_W-1:0] steps_conv_q, steps_pool_q, steps_dens_q;
  logic [STEP_W-1:0] step_q, step_inc, steps_cur;

  logic [DIV_W-1:0]  div_conv_n, div_pool_n, div_dens_n;
  logic [STEP_W-1:0] steps_conv_n, steps_pool_n, steps_dens_n;
  logic [DIV_W-1:0]  div_sel, div_m1;
  logic [STEP_W-1:0] steps_sel;

  logic load, run_now, pause_eff, tick, strobe, phase_end;

  assign run_now = is_run(state_q);

`ifdef LAYER_SCHED_PAUSE_EN
  assign pause_eff = pause && run_now;
`else
  assign pause_eff = 1'b0;
`endif

  assign load   = (state_q == ST_IDLE) && start;
  assign strobe = tick && !pause_eff;

  // The strobe generator looks one cycle ahead, so on the start cycle it must
  // see the cfg values that are about to be captured, not the old shadows.
  assign div_conv_n   = load ? cfg_div_conv   : div_conv_q;
  assign div_pool_n   = load ? cfg_div_pool   : div_pool_q;
  assign div_dens_n   = load ? cfg_div_dens   : div_dens_q;
  assign steps_conv_n = load ? cfg_steps_conv : steps_conv_q;
  assign steps_pool_n = load ? cfg_steps_pool : steps_pool_q;
  assign steps_dens_n = load ? cfg_steps_dens : steps_dens_q;

  always_comb begin
    steps_cur = '0;
    case (state_q)
      ST_CONV: steps_cur = steps_conv_q;
      ST_POOL: steps_cur = steps_pool_q;
      ST_DENS: steps_cur = steps_dens_q;
      default: steps_cur = '0;
    endcase
  end

  assign step_inc  = step_q + 1'b1;
  assign phase_end = (steps_cur == '0) || (strobe && (step_inc == steps_cur));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start)     state_d = ST_CONV;
      ST_CONV: if (phase_end) state_d = ST_POOL;
      ST_POOL: if (phase_end) state_d = ST_DENS;
      ST_DENS: if (phase_end) state_d = ST_DONE;
      ST_DONE:                state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    div_sel   = '0;
    steps_sel = '0;
    case (state_d)
      ST_CONV: begin div_sel = div_conv_n; steps_sel = steps_conv_n; end
      ST_POOL: begin div_sel = div_pool_n; steps_sel = steps_pool_n; end
      ST_DENS: begin div_sel = div_dens_n; steps_sel = steps_dens_n; end
      default: begin div_sel = '0;         steps_sel = '0;           end
    endcase
  end

  // Divisors 0 and 1 both mean a strobe every cycle.
  assign div_m1 = (div_sel[DIV_W-1:1] == '0) ? '0 : div_sel - 1'b1;

  layer_strobe_gen #(.DIV_W(DIV_W)) u_strobe_gen (
    .clock_in (clock_in),
    .reset    (reset),
    .clear    (state_d != state_q),
    .hold     (pause_eff),
    .run      (is_run(state_d) && (steps_sel != '0)),
    .div_m1   (div_m1),
    .tick     (tick)
  );

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      step_q       <= '0;
      div_conv_q   <= '0;
      div_pool_q   <= '0;
      div_dens_q   <= '0;
      steps_conv_q <= '0;
      steps_pool_q <= '0;
      steps_dens_q <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        div_conv_q   <= cfg_div_conv;
        div_pool_q   <= cfg_div_pool;
        div_dens_q   <= cfg_div_dens;
        steps_conv_q <= cfg_steps_conv;
        steps_pool_q <= cfg_steps_pool;
        steps_dens_q <= cfg_steps_dens;
      end
      if (state_d != state_q) step_q <= '0;
      else if (strobe)        step_q <= step_inc;
    end
  end

  assign en_conv  = strobe && (state_q == ST_CONV);
  assign en_pool  = strobe && (state_q == ST_POOL);
  assign en_dens  = strobe && (state_q == ST_DENS);
  assign busy     = run_now;
  assign done     = (state_q == ST_DONE);
  assign step_idx = step_q;

  always_comb begin
    case (state_q)
      ST_CONV: phase = PHASE_CONV;
      ST_POOL: phase = PHASE_POOL;
      ST_DENS: phase = PHASE_DENS;
      default: phase = PHASE_IDLE;
    endcase
  end

endmodule
